des3_block_feeder: RTL

- Upstream front-end of the 3DES encrypt→decrypt chain.
- Accepts a byte stream with valid/ready, packs bytes MSB-first into 64-bit blocks, and applies PKCS#7 padding on the final block.
- Launches one chain operation per block with a single start pulse, waits for chain completion, then presents the captured ciphertext plus a round-trip match flag on a valid/ready output.
- A watchdog flags a hung chain.

---
 rtl/des3_block_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/des3_block_feeder.sv
// Byte-stream front-end for the 3DES encrypt->decrypt chain: packs bytes MSB-first into
// 64-bit blocks with PKCS#7 padding, launches one chain run per block and returns the result.
module des3_block_feeder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        des_start,
  output logic [63:0] des_plaintext,
  input  logic [63:0] des_ciphertext,
  input  logic [63:0] des_recovered,
  input  logic        des_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_cipher,
  output logic        out_last,
  output logic        out_match,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [63:0] PadBlock = 64'h0808_0808_0808_0808;
  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    StFill,
    StLaunch,
    StWait,
    StOut,
    StErr
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [2:0]  r_count;
  logic        r_pad_pending;
  logic        r_last_flag;
  logic [15:0] r_wdog;
  logic [63:0] r_plain;
  logic [63:0] r_cipher;
  logic        r_out_last;
  logic        r_out_match;

  logic        w_accept;
  logic        w_final;
  logic        w_wdog_hit;
  logic [7:0]  w_pad_byte;
  logic [63:0] w_block;

  assign w_accept   = in_valid && (r_state == StFill);
  assign w_final    = w_accept && (in_last || (r_count == 3'd7));
  assign w_wdog_hit = (r_wdog == WdogLast);
  // Pad value is the number of bytes still missing after the current one.
  assign w_pad_byte = {5'd0, 3'd7 - r_count};

  always_comb begin
    w_block = r_plain;
    for (int i = 0; i < 8; i++) begin
      if (i == int'(r_count)) begin
        w_block[63-8*i -: 8] = in_byte;
      end else if (in_last && (i > int'(r_count))) begin
        w_block[63-8*i -: 8] = w_pad_byte;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFill:   if (w_final) w_state_next = StLaunch;
      StLaunch: w_state_next = StWait;
      StWait: begin
        if (des_done) begin
          w_state_next = StOut;
        end else if (w_wdog_hit) begin
          w_state_next = StErr;
        end
      end
      StOut: begin
        if (out_ready) w_state_next = r_pad_pending ? StLaunch : StFill;
      end
      StErr:    w_state_next = StErr;
      default:  w_state_next = StFill;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_count       <= 3'd0;
      r_pad_pending <= 1'b0;
      r_last_flag   <= 1'b0;
      r_wdog        <= 16'd0;
      r_plain       <= 64'd0;
      r_cipher      <= 64'd0;
      r_out_last    <= 1'b0;
      r_out_match   <= 1'b0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (w_accept) begin
            r_plain <= w_block;
            if (w_final) begin
              r_count       <= 3'd0;
              // A full final block needs a whole extra pad block behind it.
              r_pad_pending <= in_last && (r_count == 3'd7);
              r_last_flag   <= in_last && (r_count != 3'd7);
            end else begin
              r_count <= r_count + 3'd1;
            end
          end
        end
        StLaunch: r_wdog <= 16'd0;
        StWait: begin
          if (des_done) begin
            r_cipher    <= des_ciphertext;
            r_out_match <= (des_recovered == r_plain);
            r_out_last  <= r_last_flag;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        StOut: begin
          if (out_ready) begin
            if (r_pad_pending) begin
              r_plain       <= PadBlock;
              r_pad_pending <= 1'b0;
              r_last_flag   <= 1'b1;
            end else begin
              r_count <= 3'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (r_state == StFill);
  assign des_start     = (r_state == StLaunch);
  assign des_plaintext = r_plain;
  assign out_valid     = (r_state == StOut);
  assign out_cipher    = r_cipher;
  assign out_last      = r_out_last;
  assign out_match     = r_out_match;
  assign busy          = (r_state != StFill);
  assign timeout_err   = (r_state == StErr);

endmodule
